// File: rtl/fetch_pkg.sv
// Shared fetch/control constants: FSM states, next-PC source codes and branch condition codes.
// control_file imports the same package so both ends agree on the encodings.
package fetch_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_REG = 2'b11;

  localparam logic [2:0] BT_ALWAYS = 3'b000;
  localparam logic [2:0] BT_ZERO   = 3'b001;
  localparam logic [2:0] BT_NZERO  = 3'b010;
  localparam logic [2:0] BT_SIGN   = 3'b011;
  localparam logic [2:0] BT_NSIGN  = 3'b100;
  localparam logic [2:0] BT_CARRY  = 3'b101;
  localparam logic [2:0] BT_OVF    = 3'b110;
  localparam logic [2:0] BT_NEVER  = 3'b111;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, region jump or register jump,
// gated by the branch condition evaluated on the ALU flags. Requires ADDR_W >= 28.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic [2:0]        branch_type,
  input  logic [1:0]        counter_selector,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              flag_ovf,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] next_pc
);

  function automatic logic cond_met(input logic [2:0] bt, input logic z, input logic s,
                                    input logic c, input logic v);
    logic r;
    case (bt)
      BT_ALWAYS: r = 1'b1;
      BT_ZERO:   r = z;
      BT_NZERO:  r = !z;
      BT_SIGN:   r = s;
      BT_NSIGN:  r = !s;
      BT_CARRY:  r = c;
      BT_OVF:    r = v;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  logic [ADDR_W-1:0]        seq_pc;
  logic [ADDR_W-1:0]        target;
  logic signed [ADDR_W-1:0] br_offset;
  logic                     take;
  logic [7:0]               field_unused;

  assign seq_pc       = pc + ADDR_W'(4);
  // Word offset, sign-extended from the 16-bit immediate.
  assign br_offset    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign take         = cond_met(branch_type, flag_zero, flag_sign, flag_carry, flag_ovf);
  assign field_unused = {instr[31:26], reg_target[1:0]};

  always_comb begin
    target = seq_pc;
    case (counter_selector)
      SEL_BR:  target = seq_pc + br_offset;
      SEL_J:   target[27:0] = {instr[25:0], 2'b00};
      SEL_REG: target = {reg_target[ADDR_W-1:2], 2'b00};
      default: target = seq_pc;
    endcase
    next_pc = ((counter_selector != SEL_SEQ) && take) ? target : seq_pc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: START -> FETCH (req/ack) -> HOLD (wait for retire) -> FETCH.
// Optional macro FETCH_TIMEOUT_EN adds a fetch watchdog with a sticky fetch_err flag.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              exec_done,
  input  logic [2:0]        branch_type,
  input  logic [1:0]        counter_selector,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              flag_ovf,
  input  logic [ADDR_W-1:0] reg_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        function_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_err
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] next_pc;
  logic              fetch_req;
  logic              ack_take;
  logic              retire;

  assign imem_req     = fetch_req;
  assign imem_addr    = pc;
  assign pc_plus4     = pc + ADDR_W'(4);
  assign opcode       = instr[31:26];
  assign function_val = instr[5:0];
  // Acks are only honoured while a request is actually on the bus.
  assign ack_take     = fetch_req && imem_ack;
  assign retire       = (state == HOLD) && exec_done && !stall;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       backoff;
  logic       err_q;

  assign fetch_req = (state == FETCH) && !backoff;
  assign fetch_err = err_q;

  // Counter is held at zero outside FETCH, so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      backoff  <= 1'b0;
      err_q    <= 1'b0;
    end else if (state != FETCH) begin
      wait_cnt <= '0;
      backoff  <= 1'b0;
    end else if (backoff) begin
      wait_cnt <= '0;
      backoff  <= 1'b0;
    end else if (!imem_ack) begin
      if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
        err_q   <= 1'b1;
        backoff <= 1'b1;
      end
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  logic [7:0] timeout_unused;

  assign fetch_req      = (state == FETCH);
  assign fetch_err      = 1'b0;
  assign timeout_unused = 8'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= START;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        START: state <= FETCH;
        FETCH: begin
          if (ack_take) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (retire) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= START;
      endcase
    end
  end

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_calc (
    .pc               (pc),
    .instr            (instr),
    .branch_type      (branch_type),
    .counter_selector (counter_selector),
    .flag_zero        (flag_zero),
    .flag_sign        (flag_sign),
    .flag_carry       (flag_carry),
    .flag_ovf         (flag_ovf),
    .reg_target       (reg_target),
    .next_pc          (next_pc)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and program-counter stage directly upstream of control_file.
- Holds the PC and fetches one 32-bit instruction per turn over a req/ack memory handshake.
- Presents the instruction with its opcode/function_val split out to control_file, then waits for execute to retire it.
- On retire, computes the next PC from control_file's branch_type/counter_selector plus the ALU flags.

Parameters:
- ADDR_W, 32, PC/address width; the computed PC is always word-aligned.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT_CYCLES, 255, fetch watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  pipeline hold; while high, exec_done is ignored.
- exec_done  in  1  current instruction retired; the branch inputs below are valid this cycle.
- branch_type  in  3  condition code from control_file.
- counter_selector  in  2  next-PC source from control_file.
- flag_zero, flag_sign, flag_carry, flag_ovf  in  1 each  ALU flags, sampled with exec_done.
- reg_target  in  ADDR_W  register value used for register jumps.
- instr_valid  out  1  instr/opcode/function_val are valid.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- function_val  out  6  instr[5:0].
- pc  out  ADDR_W  address of the instruction in instr.
- pc_plus4  out  ADDR_W  pc+4, for link writes.
- fetch_err  out  1  sticky timeout flag; tied 0 when FETCH_TIMEOUT_EN is not defined.

Behaviour:
- Reset (rst_n=0 at an edge), from any state and mid-handshake included:
  - state=START, pc=RESET_PC.
  - imem_req=0, instr_valid=0, instr=0, fetch_err=0.
  - A pending ack is discarded.
- States:
  - START: one cycle, then go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1, go to HOLD. imem_req drops in the cycle after the ack.
  - HOLD: instr_valid=1, outputs stable. On exec_done & !stall: pc<=next_pc, instr_valid<=0, go to FETCH.
- Fetch latency: the earliest imem_req follows 1 cycle after retire.
- imem_ack outside FETCH is ignored. exec_done outside HOLD is ignored.
- counter_selector encoding:
  - 00: next_pc = pc+4. branch_type is ignored.
  - 01 (branch): target = pc+4 + (sext(instr[15:0])<<2).
  - 10 (jump): target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11 (register): target = {reg_target[31:2], 2'b00}. The low 2 bits are forced to zero.
- branch_type encoding (meaningful only when counter_selector != 00):
  - 000 always, 001 zero, 010 !zero, 011 sign, 100 !sign, 101 carry, 110 ovf, 111 never.
  - Condition true: next_pc = target. Condition false: next_pc = pc+4.
- All PC arithmetic is modulo 2^ADDR_W: 0xFFFF_FFFC+4 wraps to 0.
- stall high together with exec_done: retire is deferred. exec_done must be re-asserted once stall is low.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: fetch_err<=1 (sticky until reset), imem_req drops for 1 cycle, then the same pc is re-requested.
- Undefined: no counter; fetch_err is tied 0; FETCH waits indefinitely.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (START, FETCH, HOLD);
  - localparams for the counter_selector codes (SEL_SEQ, SEL_BR, SEL_J, SEL_REG);
  - localparams for the branch_type codes (BT_ALWAYS..BT_NEVER).
- control_file imports the same constants.
- One combinational sub-module, next_pc_calc: inputs pc, instr, flags, reg_target, selectors; output next_pc.

Test Plan:
- Reset then ack at 0x0 with rdata 0x0000_0020 -> imem_addr=0x0, opcode=0, function_val=32, instr_valid=1; exec_done with sel=00 -> next imem_addr=0x4.
- Branch: pc=0x10, instr[15:0]=0xFFFE, sel=01, bt=001:
  - zero=1 -> next pc=0x0C;
  - repeat with zero=0 -> pc=0x14.
- Jump and register jump:
  - pc=0x20, instr[25:0]=0x40, sel=10, bt=000 -> pc=0x100;
  - sel=11, reg_target=0x203 -> pc=0x200.
- Wrap and never: pc=0xFFFF_FFFC, sel=00 -> pc=0x0; sel=01, bt=111 -> pc=pc+4.
- Stall and stray handshakes:
  - stall=1 with exec_done -> instr_valid stays 1, pc unchanged;
  - stray imem_ack in HOLD -> instr unchanged.
- Reset mid-FETCH (imem_req=1) -> next cycle imem_req=0, pc=RESET_PC. With FETCH_TIMEOUT_EN: no ack for 255 cycles -> fetch_err=1 and re-request at the same address.
